// File: rtl/operand_fetch_if.sv
// Operand-fetch stage bus: decoder, register-file read, immediate fetch,
// and the handshake toward the addressing-mode stage.
interface operand_fetch_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              dec_valid;
  logic              dec_ready;
  logic [3:0]        dec_opcode;
  logic [REG_AW-1:0] dec_rd;
  logic [REG_AW-1:0] dec_rs;
  logic              rf_rd_en;
  logic [REG_AW-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              imm_req;
  logic              imm_ack;
  logic [DATA_W-1:0] imm_data;
  logic              pc_inc;
  logic              op_valid;
  logic              op_ready;
  logic [3:0]        op_opcode;
  logic [DATA_W-1:0] op2_data;
  logic [15:0]       op1_regaddr;
  logic [15:0]       op2_regaddr;
  logic              fetch_err;

  modport master (
    input  dec_valid, dec_opcode, dec_rd, dec_rs, rf_rd_data, imm_ack, imm_data, op_ready,
    output dec_ready, rf_rd_en, rf_rd_addr, imm_req, pc_inc, op_valid,
           op_opcode, op2_data, op1_regaddr, op2_regaddr, fetch_err
  );

  modport slave (
    output dec_valid, dec_opcode, dec_rd, dec_rs, rf_rd_data, imm_ack, imm_data, op_ready,
    input  dec_ready, rf_rd_en, rf_rd_addr, imm_req, pc_inc, op_valid,
           op_opcode, op2_data, op1_regaddr, op2_regaddr, fetch_err
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: register read for MOV, trailing immediate for MVI/LDA.
// Define OPFETCH_IMM_TIMEOUT_EN to abort a 16-cycle unanswered immediate fetch.
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic           clk,
  input  logic           rst,
  operand_fetch_if.master bus
);
  localparam logic [3:0] OP_MOV = 4'b1011;
  localparam logic [3:0] OP_MVI = 4'b1100;
  localparam logic [3:0] OP_LDA = 4'b1101;

  typedef enum logic [2:0] {IDLE, RD, CAP, IMM, OUT} state_t;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [DATA_W-1:0] op2_data;
    logic [15:0]       op1_regaddr;
    logic [15:0]       op2_regaddr;
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q;
  logic [REG_AW-1:0] rs_q;
`ifdef OPFETCH_IMM_TIMEOUT_EN
  logic [3:0]        tmo_cnt_q;
  logic              err_q;
  logic              tmo_hit;
  assign tmo_hit = (state_q == IMM) && !bus.imm_ack && (tmo_cnt_q == 4'd15);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.dec_valid) begin
        case (bus.dec_opcode)
          OP_MOV:         state_d = RD;
          OP_MVI, OP_LDA: state_d = IMM;
          default:        state_d = OUT;
        endcase
      end
      RD:   state_d = CAP;
      CAP:  state_d = OUT;
      IMM: begin
        if (bus.imm_ack) state_d = OUT;
`ifdef OPFETCH_IMM_TIMEOUT_EN
        else if (tmo_hit) state_d = OUT;
`endif
      end
      OUT:  if (bus.op_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake strobes decode straight from state so reset values fall out of IDLE.
  assign bus.dec_ready   = (state_q == IDLE);
  assign bus.rf_rd_en    = (state_q == RD);
  assign bus.rf_rd_addr  = (state_q == RD) ? rs_q : '0;
  assign bus.imm_req     = (state_q == IMM);
  assign bus.pc_inc      = (state_q == IMM) && bus.imm_ack;
  assign bus.op_valid    = (state_q == OUT);
  assign bus.op_opcode   = op_q.opcode;
  assign bus.op2_data    = op_q.op2_data;
  assign bus.op1_regaddr = op_q.op1_regaddr;
  assign bus.op2_regaddr = op_q.op2_regaddr;
`ifdef OPFETCH_IMM_TIMEOUT_EN
  assign bus.fetch_err   = err_q;
`else
  assign bus.fetch_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      rs_q    <= '0;
`ifdef OPFETCH_IMM_TIMEOUT_EN
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.dec_valid) begin
          op_q.opcode      <= bus.dec_opcode;
          op_q.op2_data    <= '0;
          op_q.op2_regaddr <= '0;
          op_q.op1_regaddr <= {{(16-REG_AW){1'b0}}, bus.dec_rd};
          rs_q             <= bus.dec_rs;
`ifdef OPFETCH_IMM_TIMEOUT_EN
          tmo_cnt_q        <= '0;
`endif
        end
        CAP: op_q.op2_data <= bus.rf_rd_data;
        IMM: begin
          if (bus.imm_ack) op_q.op2_regaddr <= 16'(bus.imm_data);
`ifdef OPFETCH_IMM_TIMEOUT_EN
          // An abandoned fetch surfaces as a NOP so downstream never sees stale data.
          else if (tmo_hit) begin
            op_q.opcode      <= 4'b0000;
            op_q.op2_regaddr <= '0;
            err_q            <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 4'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  int   pc_cnt = 0;
  int   rd_cnt = 0;
  int   req_cnt = 0;
  logic [15:0] rf [8];

  operand_fetch_if #(.DATA_W(16), .REG_AW(3)) bus ();
  operand_fetch #(.DATA_W(16), .REG_AW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Register file model: data returns the cycle after the read strobe.
  always @(posedge clk) if (bus.rf_rd_en) bus.rf_rd_data <= rf[bus.rf_rd_addr];

  always @(negedge clk) begin
    if (bus.pc_inc)   pc_cnt++;
    if (bus.rf_rd_en) rd_cnt++;
    if (bus.imm_req)  req_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
    bus.dec_valid = 1'b1; bus.dec_opcode = op; bus.dec_rd = rd; bus.dec_rs = rs;
    tick();
    bus.dec_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.op_ready = 1'b1; tick(); bus.op_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0]  flags;
    logic [51:0] words;
    int p0;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    flags = {bus.dec_ready, bus.op_valid, bus.imm_req, bus.rf_rd_en, bus.pc_inc, bus.fetch_err};
    checks++; if (flags !== 6'b100000) $display("FAIL reset_flags: got %b exp %b", flags, 6'b100000); else passed++;
    words = {bus.op_opcode, bus.op2_data, bus.op1_regaddr, bus.op2_regaddr};
    checks++; if (words !== 52'h0 || bus.rf_rd_addr !== 3'd0) $display("FAIL reset_ops: got %h/%h exp 0", words, bus.rf_rd_addr); else passed++;
    // reset while an MVI waits for its immediate
    accept(4'b1100, 3'd3, 3'd0);
    tick();
    checks++; if (bus.imm_req !== 1'b1) $display("FAIL mid_imm_req: got %b exp 1", bus.imm_req); else passed++;
    p0 = pc_cnt;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    tick();
    flags = {bus.dec_ready, bus.op_valid, bus.imm_req, bus.rf_rd_en, bus.pc_inc, bus.fetch_err};
    checks++; if (flags !== 6'b100000) $display("FAIL midrst_flags: got %b exp %b", flags, 6'b100000); else passed++;
    words = {bus.op_opcode, bus.op2_data, bus.op1_regaddr, bus.op2_regaddr};
    checks++; if (words !== 52'h0 || pc_cnt != p0) $display("FAIL midrst_ops: got %h pc %0d exp 0 pc %0d", words, pc_cnt, p0); else passed++;
  endtask

  task automatic test_mov();
    rf[5] = 16'hBEEF;
    accept(4'b1011, 3'd2, 3'd5);
    checks++; if ({bus.rf_rd_en, bus.rf_rd_addr, bus.op_valid} !== {1'b1, 3'd5, 1'b0})
      $display("FAIL mov_rd: got en %b addr %0d v %b exp 1 5 0", bus.rf_rd_en, bus.rf_rd_addr, bus.op_valid); else passed++;
    tick();
    checks++; if ({bus.rf_rd_en, bus.op_valid} !== 2'b00) $display("FAIL mov_cap: got %b exp 00", {bus.rf_rd_en, bus.op_valid}); else passed++;
    tick();
    checks++; if ({bus.op_valid, bus.op_opcode, bus.op2_data, bus.op1_regaddr, bus.op2_regaddr} !== {1'b1, 4'hB, 16'hBEEF, 16'h0002, 16'h0000})
      $display("FAIL mov_out: got v %b op %h d %h r1 %h r2 %h exp 1 b beef 0002 0000", bus.op_valid, bus.op_opcode, bus.op2_data, bus.op1_regaddr, bus.op2_regaddr); else passed++;
    handshake();
    checks++; if ({bus.dec_ready, bus.op_valid} !== 2'b10) $display("FAIL mov_done: got %b exp 10", {bus.dec_ready, bus.op_valid}); else passed++;
  endtask

  task automatic test_unrecognised();
    int r0, q0, p0;
    r0 = rd_cnt; q0 = req_cnt; p0 = pc_cnt;
    bus.imm_ack = 1'b1; bus.imm_data = 16'hDEAD;
    accept(4'b0010, 3'd1, 3'd6);
    checks++; if ({bus.op_valid, bus.op_opcode, bus.op2_data, bus.op1_regaddr, bus.op2_regaddr} !== {1'b1, 4'h2, 16'h0, 16'h0001, 16'h0})
      $display("FAIL unrec_out: got v %b op %h d %h r1 %h r2 %h exp 1 2 0000 0001 0000", bus.op_valid, bus.op_opcode, bus.op2_data, bus.op1_regaddr, bus.op2_regaddr); else passed++;
    handshake();
    bus.imm_ack = 1'b0;
    checks++; if (rd_cnt != r0 || req_cnt != q0 || pc_cnt != p0)
      $display("FAIL unrec_side: got rd %0d req %0d pc %0d exp %0d %0d %0d", rd_cnt, req_cnt, pc_cnt, r0, q0, p0); else passed++;
  endtask

  task automatic test_mvi();
    int p0;
    p0 = pc_cnt;
    accept(4'b1100, 3'd3, 3'd0);
    checks++; if (bus.imm_req !== 1'b1) $display("FAIL mvi_req: got %b exp 1", bus.imm_req); else passed++;
    for (int i = 0; i < 3; i++) tick();
    bus.imm_ack = 1'b1; bus.imm_data = 16'h1234;
    #1;
    checks++; if ({bus.imm_req, bus.pc_inc, bus.op_valid} !== 3'b110) $display("FAIL mvi_ack: got %b exp 110", {bus.imm_req, bus.pc_inc, bus.op_valid}); else passed++;
    tick();
    bus.imm_ack = 1'b0;
    checks++; if ({bus.imm_req, bus.op_valid, bus.op_opcode, bus.op2_regaddr, bus.op1_regaddr, bus.op2_data} !== {1'b0, 1'b1, 4'hC, 16'h1234, 16'h0003, 16'h0})
      $display("FAIL mvi_out: got req %b v %b op %h r2 %h r1 %h d %h exp 0 1 c 1234 0003 0000", bus.imm_req, bus.op_valid, bus.op_opcode, bus.op2_regaddr, bus.op1_regaddr, bus.op2_data); else passed++;
    handshake();
    checks++; if (pc_cnt - p0 != 1) $display("FAIL mvi_pc_inc: got %0d pulses exp 1", pc_cnt - p0); else passed++;
  endtask

  task automatic test_lda_min();
    accept(4'b1101, 3'd6, 3'd0);
    bus.imm_ack = 1'b1; bus.imm_data = 16'hA5A5;
    tick();
    bus.imm_ack = 1'b0;
    checks++; if ({bus.op_valid, bus.op_opcode, bus.op1_regaddr, bus.op2_regaddr} !== {1'b1, 4'hD, 16'h0006, 16'hA5A5})
      $display("FAIL lda_min: got v %b op %h r1 %h r2 %h exp 1 d 0006 a5a5", bus.op_valid, bus.op_opcode, bus.op1_regaddr, bus.op2_regaddr); else passed++;
    handshake();
  endtask

  task automatic test_backpressure();
    rf[6] = 16'h5A5A;
    accept(4'b1011, 3'd4, 3'd6);
    tick(); tick();
    bus.dec_valid = 1'b1; bus.dec_opcode = 4'b0010; bus.dec_rd = 3'd1; bus.dec_rs = 3'd0;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.op_valid, bus.dec_ready, bus.op_opcode, bus.op2_data, bus.op1_regaddr} !== {1'b1, 1'b0, 4'hB, 16'h5A5A, 16'h0004})
        $display("FAIL bp_hold%0d: got v %b rdy %b op %h d %h r1 %h exp 1 0 b 5a5a 0004", i, bus.op_valid, bus.dec_ready, bus.op_opcode, bus.op2_data, bus.op1_regaddr); else passed++;
      tick();
    end
    handshake();
    checks++; if ({bus.dec_ready, bus.op_valid} !== 2'b10) $display("FAIL bp_idle: got %b exp 10", {bus.dec_ready, bus.op_valid}); else passed++;
    tick();
    bus.dec_valid = 1'b0;
    checks++; if ({bus.op_valid, bus.op_opcode, bus.op1_regaddr} !== {1'b1, 4'h2, 16'h0001})
      $display("FAIL bp_second: got v %b op %h r1 %h exp 1 2 0001", bus.op_valid, bus.op_opcode, bus.op1_regaddr); else passed++;
    handshake();
  endtask

`ifdef OPFETCH_IMM_TIMEOUT_EN
  task automatic test_timeout();
    int p0, q0, n;
    p0 = pc_cnt; q0 = req_cnt; n = 0;
    accept(4'b1101, 3'd5, 3'd0);
    while (!bus.op_valid && n < 40) begin tick(); n++; end
    checks++; if (n != 16 || req_cnt - q0 != 16) $display("FAIL tmo_len: got %0d cycles %0d req exp 16 16", n, req_cnt - q0); else passed++;
    checks++; if ({bus.op_valid, bus.fetch_err, bus.op_opcode, bus.op2_regaddr, bus.imm_req} !== {1'b1, 1'b1, 4'h0, 16'h0, 1'b0} || pc_cnt != p0)
      $display("FAIL tmo_out: got v %b err %b op %h r2 %h req %b pc %0d exp 1 1 0 0000 0 %0d", bus.op_valid, bus.fetch_err, bus.op_opcode, bus.op2_regaddr, bus.imm_req, pc_cnt, p0); else passed++;
    handshake();
    accept(4'b1011, 3'd1, 3'd5);
    tick(); tick();
    checks++; if ({bus.op_valid, bus.fetch_err, bus.op2_data} !== {1'b1, 1'b1, 16'hBEEF}) $display("FAIL tmo_sticky: got v %b err %b d %h exp 1 1 beef", bus.op_valid, bus.fetch_err, bus.op2_data); else passed++;
    handshake();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (bus.fetch_err !== 1'b0) $display("FAIL tmo_clear: got %b exp 0", bus.fetch_err); else passed++;
  endtask
`else
  task automatic test_long_wait();
    accept(4'b1101, 3'd5, 3'd0);
    for (int i = 0; i < 19; i++) tick();
    checks++; if ({bus.imm_req, bus.op_valid, bus.fetch_err} !== 3'b100) $display("FAIL wait_req: got %b exp 100", {bus.imm_req, bus.op_valid, bus.fetch_err}); else passed++;
    bus.imm_ack = 1'b1; bus.imm_data = 16'h0F0F;
    tick();
    bus.imm_ack = 1'b0;
    checks++; if ({bus.op_valid, bus.fetch_err, bus.op_opcode, bus.op2_regaddr} !== {1'b1, 1'b0, 4'hD, 16'h0F0F})
      $display("FAIL wait_out: got v %b err %b op %h r2 %h exp 1 0 d 0f0f", bus.op_valid, bus.fetch_err, bus.op_opcode, bus.op2_regaddr); else passed++;
    handshake();
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.dec_valid = 1'b0; bus.dec_opcode = 4'h0; bus.dec_rd = 3'd0; bus.dec_rs = 3'd0;
    bus.imm_ack = 1'b0; bus.imm_data = 16'h0; bus.op_ready = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    test_reset();
    test_mov();
    test_unrecognised();
    test_mvi();
    test_lda_min();
    test_backpressure();
`ifdef OPFETCH_IMM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
